// File: rtl/orb_bank_scheduler.sv
// Ping-pong scheduler for the two orbit frame RAM banks: the filler writes the
// fill bank while the transmitter drains the other, swapping at frame boundaries.
module orb_bank_scheduler #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 1024,
  parameter int INIT_CYC  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  output logic              orb_switch,
  input  logic              rd_req,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_start,
  output logic              fill_bank,
  output logic [ADDR_W-1:0] bank0_addr,
  output logic [ADDR_W-1:0] bank1_addr,
  output logic [DATA_W-1:0] bank0_wdata,
  output logic [DATA_W-1:0] bank1_wdata,
  output logic              bank0_we,
  output logic              bank1_we,
  input  logic [DATA_W-1:0] bank0_q,
  input  logic [DATA_W-1:0] bank1_q,
  output logic [7:0]        underrun_cnt,
  output logic              overrun,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
  logic              orb_switch_q, orb_switch_d;
  logic              fill_bank_q, fill_bank_d;
  logic              fill_done_q, fill_done_d;
  logic              overrun_q, overrun_d;
  logic              wr_en_prev_q;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              rd_ready_q, rd_ready_d;
  logic              rd_addr_stage_q, rd_addr_stage_d;
  logic              rd_q_stage_q, rd_q_stage_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              frame_start_q, frame_start_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_W-1:0] wdata0_q, wdata0_d, wdata1_q, wdata1_d;
  logic              we0_q, we0_d, we1_q, we1_d;
  logic [7:0]        underrun_q, underrun_d;
  logic              wr_edge, rd_accept, last_word, do_swap;

  // Read handshake: a word is taken only in a cycle with rd_ready=1 and
  // rd_req=1; rd_ready then stays low until the cycle its rd_valid is shown.
  assign wr_edge   = wr_en & ~wr_en_prev_q & (state_q != S_INIT);
  assign rd_accept = (state_q == S_RUN) & rd_ready_q & rd_req;

  always_comb begin
    state_d         = state_q;
    init_cnt_d      = init_cnt_q;
    orb_switch_d    = orb_switch_q;
    fill_bank_d     = fill_bank_q;
    fill_done_d     = fill_done_q;
    overrun_d       = overrun_q;
    rd_ptr_d        = rd_ptr_q;
    rd_ready_d      = rd_ready_q;
    rd_addr_stage_d = 1'b0;
    rd_q_stage_d    = rd_addr_stage_q;
    rd_data_d       = rd_data_q;
    rd_valid_d      = 1'b0;
    frame_start_d   = 1'b0;
    addr0_d         = addr0_q;
    addr1_d         = addr1_q;
    wdata0_d        = wdata0_q;
    wdata1_d        = wdata1_q;
    we0_d           = 1'b0;
    we1_d           = 1'b0;
    underrun_d      = underrun_q;
    last_word       = 1'b0;
    do_swap         = 1'b0;

    if (wr_edge) begin
      if (fill_done_q) begin
        overrun_d = 1'b1;
      end else begin
        if (fill_bank_q) begin
          addr1_d  = wr_addr;
          wdata1_d = wr_data;
          we1_d    = 1'b1;
        end else begin
          addr0_d  = wr_addr;
          wdata0_d = wr_data;
          we0_d    = 1'b1;
        end
        if (wr_addr == LAST_ADDR) fill_done_d = 1'b1;
      end
    end

    // The drain bank is always the one not being filled.
    if (rd_accept) begin
      rd_ready_d      = 1'b0;
      rd_addr_stage_d = 1'b1;
      if (fill_bank_q) addr0_d = rd_ptr_q;
      else             addr1_d = rd_ptr_q;
    end

    if (rd_q_stage_q) begin
      rd_data_d  = fill_bank_q ? bank0_q : bank1_q;
      rd_valid_d = 1'b1;
      rd_ready_d = 1'b1;
      last_word  = (rd_ptr_q == LAST_ADDR);
      rd_ptr_d   = last_word ? '0 : rd_ptr_q + ADDR_W'(1);
    end

    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          init_cnt_d   = '0;
          orb_switch_d = ~orb_switch_q;
          state_d      = S_PRIME;
        end else begin
          init_cnt_d = init_cnt_q + CNT_W'(1);
        end
      end
      S_PRIME: do_swap = fill_done_q;
      S_RUN: begin
        if (last_word) begin
          if (fill_done_q)               do_swap    = 1'b1;
          else if (underrun_q != 8'hFF)  underrun_d = underrun_q + 8'd1;
        end
      end
      S_SWAP: begin
        state_d    = S_RUN;
        rd_ready_d = 1'b1;
      end
      default: state_d = S_INIT;
    endcase

    // Swap side effects become visible during the SWAP cycle itself, so a
    // write edge seen in SWAP already lands in the new fill bank.
    if (do_swap) begin
      state_d       = S_SWAP;
      fill_bank_d   = ~fill_bank_q;
      orb_switch_d  = ~orb_switch_q;
      fill_done_d   = 1'b0;
      rd_ptr_d      = '0;
      frame_start_d = 1'b1;
      rd_ready_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_INIT;
      init_cnt_q      <= '0;
      orb_switch_q    <= 1'b0;
      fill_bank_q     <= 1'b0;
      fill_done_q     <= 1'b0;
      overrun_q       <= 1'b0;
      wr_en_prev_q    <= 1'b0;
      rd_ptr_q        <= '0;
      rd_ready_q      <= 1'b0;
      rd_addr_stage_q <= 1'b0;
      rd_q_stage_q    <= 1'b0;
      rd_data_q       <= '0;
      rd_valid_q      <= 1'b0;
      frame_start_q   <= 1'b0;
      addr0_q         <= '0;
      addr1_q         <= '0;
      wdata0_q        <= '0;
      wdata1_q        <= '0;
      we0_q           <= 1'b0;
      we1_q           <= 1'b0;
      underrun_q      <= '0;
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      orb_switch_q    <= orb_switch_d;
      fill_bank_q     <= fill_bank_d;
      fill_done_q     <= fill_done_d;
      overrun_q       <= overrun_d;
      wr_en_prev_q    <= wr_en;
      rd_ptr_q        <= rd_ptr_d;
      rd_ready_q      <= rd_ready_d;
      rd_addr_stage_q <= rd_addr_stage_d;
      rd_q_stage_q    <= rd_q_stage_d;
      rd_data_q       <= rd_data_d;
      rd_valid_q      <= rd_valid_d;
      frame_start_q   <= frame_start_d;
      addr0_q         <= addr0_d;
      addr1_q         <= addr1_d;
      wdata0_q        <= wdata0_d;
      wdata1_q        <= wdata1_d;
      we0_q           <= we0_d;
      we1_q           <= we1_d;
      underrun_q      <= underrun_d;
    end
  end

  assign orb_switch   = orb_switch_q;
  assign rd_ready     = rd_ready_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign frame_start  = frame_start_q;
  assign fill_bank    = fill_bank_q;
  assign bank0_addr   = addr0_q;
  assign bank1_addr   = addr1_q;
  assign bank0_wdata  = wdata0_q;
  assign bank1_wdata  = wdata1_q;
  assign bank0_we     = we0_q;
  assign bank1_we     = we1_q;
  assign underrun_cnt = underrun_q;
  assign overrun      = overrun_q;
  assign state_dbg    = state_q;

endmodule
